// File: rtl/i2s_rx_if.sv
// rtl/i2s_rx_if.sv - I2S capture-side serial inputs and parallel sample outputs
// master drives the serial line (codec side), slave is the receiver.
interface i2s_rx_if #(
   parameter int SAMPLE_WIDTH = 16
);
   logic                    I2S_LRCLK;
   logic                    I2S_DOUT;
   logic [SAMPLE_WIDTH-1:0] left_sample;
   logic [SAMPLE_WIDTH-1:0] right_sample;
   logic                    sample_valid;
   logic                    frame_err;

   modport master (
      output I2S_LRCLK,
      output I2S_DOUT,
      input  left_sample,
      input  right_sample,
      input  sample_valid,
      input  frame_err
   );

   modport slave (
      input  I2S_LRCLK,
      input  I2S_DOUT,
      output left_sample,
      output right_sample,
      output sample_valid,
      output frame_err
   );
endinterface

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S serial-to-parallel receiver with frame sync and short-slot detection
// Words are MSB first; the bit sampled on an LRCLK edge cycle is the LSB of the previous slot.
module i2s_rx #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int SLOT_MAX     = 64
) (
   input  logic    I2S_SCLK,
   input  logic    Reset,
   i2s_rx_if.slave bus
);
   localparam int CW = $clog2(SLOT_MAX + 1);
   localparam logic [CW-1:0] CNT_SAT  = CW'(SLOT_MAX);
   localparam logic [CW-1:0] CNT_SW   = CW'(SAMPLE_WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    lr_q, lr_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [SAMPLE_WIDTH-2:0] shreg_q, shreg_d;
   logic [SAMPLE_WIDTH-1:0] left_q, left_d;
   logic [SAMPLE_WIDTH-1:0] right_q, right_d;
   logic                    valid_q, valid_d;
   logic                    err_q, err_d;
   logic                    left_done_q, left_done_d;

   logic                    edge_w;
   logic                    fall_w;
   logic                    shift_w;
   logic [SAMPLE_WIDTH-1:0] word_w;

   assign edge_w  = bus.I2S_LRCLK ^ lr_q;
   assign fall_w  = lr_q & ~bus.I2S_LRCLK;
   assign shift_w = (cnt_q < CNT_SW);
   assign word_w  = {shreg_q, bus.I2S_DOUT};

   always_comb begin
      state_d     = state_q;
      lr_d        = bus.I2S_LRCLK;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      left_d      = left_q;
      right_d     = right_q;
      valid_d     = 1'b0;
      err_d       = err_q;
      left_done_d = left_done_q;

      case (state_q)
         ST_SYNC: begin
            // Only a falling edge marks a clean start of a left slot.
            if (fall_w) begin
               cnt_d       = '0;
               left_done_d = 1'b0;
               state_d     = ST_LEFT;
            end
         end

         ST_LEFT, ST_RIGHT: begin
            if (shift_w) begin
               shreg_d = word_w[SAMPLE_WIDTH-2:0];
               cnt_d   = cnt_q + CW'(1);
            end else begin
               cnt_d = CNT_SAT;
            end

            if (shift_w && (cnt_q == CNT_LAST)) begin
               if (state_q == ST_LEFT) begin
                  left_d      = word_w;
                  left_done_d = 1'b1;
               end else begin
                  right_d     = word_w;
                  valid_d     = left_done_q;
                  left_done_d = 1'b0;
               end
            end

            // An edge before the word is complete means we lost framing.
            if (edge_w) begin
               if (cnt_q < CNT_LAST) begin
                  err_d       = 1'b1;
                  cnt_d       = CNT_SAT;
                  left_done_d = 1'b0;
                  state_d     = ST_SYNC;
               end else begin
                  cnt_d = '0;
                  if (state_q == ST_LEFT) begin
                     state_d = ST_RIGHT;
                  end else begin
                     left_done_d = 1'b0;
                     state_d     = ST_LEFT;
                  end
               end
            end
         end

         default: begin
            cnt_d       = CNT_SAT;
            left_done_d = 1'b0;
            state_d     = ST_SYNC;
         end
      endcase
   end

   always_ff @(posedge I2S_SCLK or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_SYNC;
         lr_q        <= 1'b0;
         cnt_q       <= CNT_SAT;
         shreg_q     <= '0;
         left_q      <= '0;
         right_q     <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         left_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lr_q        <= lr_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         left_q      <= left_d;
         right_q     <= right_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         left_done_q <= left_done_d;
      end
   end

   assign bus.left_sample  = left_q;
   assign bus.right_sample = right_q;
   assign bus.sample_valid = valid_q;
   assign bus.frame_err    = err_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - randomized scoreboard bench for i2s_rx
// A slot-level model builds the serial stream and predicts completed frames.
module tb_i2s_rx;
   localparam int SW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   i2s_rx_if #(.SAMPLE_WIDTH(SW)) bus ();

   i2s_rx #(.SAMPLE_WIDTH(SW), .SLOT_MAX(64)) dut (
      .I2S_SCLK (clk),
      .Reset    (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [SW-1:0] l;
      logic [SW-1:0] r;
      int            c;
   } exp_t;

   exp_t          sb[$];
   bit            lr_s[$];
   bit            bit_s[$];
   int            exp_idx[$];
   logic [SW-1:0] exp_l[$];
   logic [SW-1:0] exp_r[$];
   int            ptr;
   bit            synced;
   bit            err_exp;
   int            checks = 0;
   int            errors = 0;
   exp_t          mon_e;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Slot position i carries word bit SW-1-i; positions past SW carry filler.
   function automatic void add_slot(bit lvl, int len, logic [SW-1:0] w, int fill);
      for (int i = 0; i < len; i++) begin
         lr_s.push_back(lvl);
         if (i < SW) bit_s.push_back(w[SW-1-i]);
         else if (fill == 2) bit_s.push_back(bit'($urandom_range(0, 1)));
         else bit_s.push_back(bit'(fill));
      end
   endfunction

   function automatic void add_preamble();
      add_slot(1'b1, 4, '0, 0);
      synced = 1'b1;
   endfunction

   function automatic void add_trailer();
      add_slot(1'b0, 4, SW'($urandom), 2);
   endfunction

   function automatic void add_frame(int ll, int rl, logic [SW-1:0] lw, logic [SW-1:0] rw, int fill);
      int rstart;
      rstart = lr_s.size() + ll;
      add_slot(1'b0, ll, lw, fill);
      add_slot(1'b1, rl, rw, fill);
      if (synced) begin
         if (ll < SW || rl < SW) begin
            err_exp = 1'b1;
            // A short right slot is caught on the next falling edge, losing that frame too.
            synced  = (ll < SW);
         end else begin
            exp_idx.push_back(rstart + SW);
            exp_l.push_back(lw);
            exp_r.push_back(rw);
         end
      end else begin
         synced = 1'b1;
      end
   endfunction

   task automatic play_to(int n);
      exp_t e;
      while (ptr < n && ptr < lr_s.size()) begin
         @(negedge clk);
         bus.I2S_LRCLK = lr_s[ptr];
         bus.I2S_DOUT  = (ptr == 0) ? 1'b0 : bit_s[ptr-1];
         if (exp_idx.size() > 0 && exp_idx[0] == ptr) begin
            e.l = exp_l.pop_front();
            e.r = exp_r.pop_front();
            e.c = cyc + 1;
            sb.push_back(e);
            void'(exp_idx.pop_front());
         end
         ptr++;
      end
   endtask

   task automatic play_all();
      play_to(lr_s.size());
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.I2S_LRCLK = 1'b0;
      bus.I2S_DOUT  = 1'b0;
      lr_s.delete();
      bit_s.delete();
      exp_idx.delete();
      exp_l.delete();
      exp_r.delete();
      ptr     = 0;
      synced  = 1'b0;
      err_exp = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_left", 32'(bus.left_sample), 0);
      chk("rst_right", 32'(bus.right_sample), 0);
      chk("rst_valid", 32'(bus.sample_valid), 0);
      chk("rst_err", 32'(bus.frame_err), 0);
      rst = 1'b0;
   endtask

   task automatic drain(string tag);
      repeat (40) @(negedge clk);
      chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
      chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'(err_exp));
   endtask

   always @(negedge clk) begin
      if (!rst && bus.sample_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got left %h right %h at cycle %0d expected no pulse",
                     bus.left_sample, bus.right_sample, cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("left_sample", 32'(bus.left_sample), 32'(mon_e.l));
            chk("right_sample", 32'(bus.right_sample), 32'(mon_e.r));
            chk("valid_cycle", 32'(cyc), 32'(mon_e.c));
         end
      end
   end

   initial begin
      int n;
      int len [2];
      bus.I2S_LRCLK = 1'b0;
      bus.I2S_DOUT  = 1'b0;

      // Single 16-bit-slot frame.
      do_reset();
      add_preamble();
      add_frame(16, 16, 16'hA5C3, 16'h1234, 0);
      add_trailer();
      play_all();
      drain("t1");

      // 32-bit slots with trailing filler ones.
      do_reset();
      add_preamble();
      for (int k = 0; k < 3; k++) add_frame(32, 32, 16'h8001, 16'h7FFE, 1);
      add_trailer();
      play_all();
      drain("t2");

      // Reset released mid left slot.
      do_reset();
      add_frame(7, 16, SW'($urandom), SW'($urandom), 2);
      play_all();
      chk("t3_left_hold", 32'(bus.left_sample), 0);
      chk("t3_right_hold", 32'(bus.right_sample), 0);
      for (int k = 0; k < 2; k++) add_frame(16, 16, SW'($urandom), SW'($urandom), 2);
      add_trailer();
      play_all();
      drain("t3");

      // Short left slot then recovery.
      do_reset();
      add_preamble();
      add_frame(10, 16, SW'($urandom), SW'($urandom), 2);
      play_all();
      chk("t4_err_set", 32'(bus.frame_err), 1);
      add_frame(16, 16, 16'h0F0F, 16'hF0F0, 0);
      add_trailer();
      play_all();
      drain("t4");

      // Asynchronous reset halfway through a right word.
      do_reset();
      add_preamble();
      add_frame(16, 16, SW'($urandom) | 16'h1, SW'($urandom) | 16'h1, 2);
      n = lr_s.size();
      add_frame(16, 16, SW'($urandom), SW'($urandom), 2);
      play_to(n + 16 + 8);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async_left", 32'(bus.left_sample), 0);
      chk("t5_async_right", 32'(bus.right_sample), 0);
      chk("t5_async_valid", 32'(bus.sample_valid), 0);
      chk("t5_async_err", 32'(bus.frame_err), 0);
      chk("t5_sb_before_reset", 32'(sb.size()), 0);
      do_reset();
      add_preamble();
      add_frame(16, 16, 16'h5555, 16'hAAAA, 0);
      add_trailer();
      play_all();
      drain("t5");

      // Back-to-back incrementing frames.
      do_reset();
      add_preamble();
      for (int k = 1; k <= 8; k++) add_frame(16, 16, SW'(k), SW'(16'h1000 + k), 0);
      add_trailer();
      play_all();
      drain("t6");

      // Random slot lengths, occasionally short, random data and filler.
      do_reset();
      add_preamble();
      for (int k = 0; k < 24; k++) begin
         for (int s = 0; s < 2; s++) begin
            n = $urandom_range(0, 9);
            len[s] = (n == 0) ? 10 : (n < 5) ? 16 : (n < 8) ? 20 : 32;
         end
         add_frame(len[0], len[1], SW'($urandom), SW'($urandom), 2);
      end
      add_trailer();
      play_all();
      drain("t7");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
